// File: rtl/alu_muldiv_sequencer_if.sv
// Request/response bus between decode/execute and the multiply sequencer,
// including the architectural HI/LO read-out and the busy indication.
interface alu_muldiv_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        flush;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;

   // Issuing side: decode/execute pipeline
   modport master (
      output req_valid, req_op, req_a, req_b, flush, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, hi, lo, busy
   );

   // Serving side: the sequencer itself
   modport slave (
      input  req_valid, req_op, req_a, req_b, flush, rsp_ready,
      output req_ready, rsp_valid, rsp_data, hi, lo, busy
   );
endinterface

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle multiply-family sequencer and owner of the HI/LO pair.
// Builds the 64-bit magnitude product with a radix-2^R shift-add loop,
// applies the sign in ACC, commits HI/LO and answers over valid/ready.
module alu_muldiv_sequencer #(
   parameter int R = 1
) (
   input logic clk,
   input logic rst_n,
   alu_muldiv_sequencer_if.slave bus
);
   localparam int CALC_CYCLES = 32 / R;
   localparam int CNT_W       = $clog2(CALC_CYCLES);

   localparam logic [2:0] OP_MUL   = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_MADD  = 3'b011;
   localparam logic [2:0] OP_MADDU = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic [1:0] {IDLE, CALC, ACC, DONE} state_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q;
   logic               neg_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [63:0]        mcand_q;
   logic [31:0]        mplier_q;
   logic [63:0]        prod_q;
   logic [31:0]        hi_q, lo_q, rsp_data_q;

   logic               accept;
   logic               is_mult_op;
   logic               is_signed_op;
   logic [31:0]        abs_a, abs_b;
   logic [63:0]        step_add;
   logic [63:0]        prod_signed;
   logic [63:0]        hilo_sum;

   assign accept       = (state_q == IDLE) && bus.req_valid && !bus.flush;
   assign is_mult_op   = (bus.req_op <= OP_MADDU);
   assign is_signed_op = (bus.req_op == OP_MUL) || (bus.req_op == OP_MULT) ||
                         (bus.req_op == OP_MADD);
   assign abs_a        = (is_signed_op && bus.req_a[31]) ? (~bus.req_a + 32'd1) : bus.req_a;
   assign abs_b        = (is_signed_op && bus.req_b[31]) ? (~bus.req_b + 32'd1) : bus.req_b;
   assign prod_signed  = neg_q ? (~prod_q + 64'd1) : prod_q;
   assign hilo_sum     = {hi_q, lo_q} + prod_signed;

   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.rsp_data = rsp_data_q;

   // Partial product for this cycle: multiplicand shifted per low multiplier bit
   always_comb begin
      step_add = '0;
      for (int i = 0; i < R; i++) begin
         if (mplier_q[i]) step_add = step_add + (mcand_q << i);
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and handshake outputs; flush always wins over progress
   always_comb begin
      state_d       = state_q;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.busy      = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            bus.req_ready = !bus.flush;
            if (accept) state_d = is_mult_op ? CALC : DONE;
         end
         CALC: begin
            if (bus.flush)          state_d = IDLE;
            else if (cnt_q == '0)   state_d = ACC;
         end
         ACC: begin
            state_d = bus.flush ? IDLE : DONE;
         end
         DONE: begin
            bus.rsp_valid = 1'b1;
            if (bus.flush || bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: operand latch, shift-add iteration and HI/LO commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= 3'b111;
         neg_q      <= 1'b0;
         cnt_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         prod_q     <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         rsp_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  op_q     <= bus.req_op;
                  neg_q    <= is_signed_op && (bus.req_a[31] ^ bus.req_b[31]);
                  mcand_q  <= {32'd0, abs_a};
                  mplier_q <= abs_b;
                  prod_q   <= '0;
                  cnt_q    <= CNT_W'(CALC_CYCLES - 1);
                  case (bus.req_op)
                     OP_MTHI: begin
                        hi_q       <= bus.req_a;
                        rsp_data_q <= lo_q;
                     end
                     OP_MTLO: begin
                        lo_q       <= bus.req_a;
                        rsp_data_q <= bus.req_a;
                     end
                     default: rsp_data_q <= lo_q;
                  endcase
               end
            end
            CALC: begin
               if (!bus.flush) begin
                  prod_q   <= prod_q + step_add;
                  mcand_q  <= mcand_q << R;
                  mplier_q <= mplier_q >> R;
                  cnt_q    <= cnt_q - 1'b1;
               end
            end
            ACC: begin
               if (!bus.flush) begin
                  case (op_q)
                     OP_MULT, OP_MULTU: begin
                        hi_q       <= prod_signed[63:32];
                        lo_q       <= prod_signed[31:0];
                        rsp_data_q <= prod_signed[31:0];
                     end
                     OP_MADD, OP_MADDU: begin
                        hi_q       <= hilo_sum[63:32];
                        lo_q       <= hilo_sum[31:0];
                        rsp_data_q <= hilo_sum[31:0];
                     end
                     default: rsp_data_q <= prod_signed[31:0];
                  endcase
               end
            end
            default: ;
         endcase
      end
   end
endmodule
